// File: rtl/rtc_bus_protocol_ctrl.sv
// Multiplexed address/data RTC bus controller: one register access per request, address phase then data phase.
// Optional RTC_CMD_ADDR_ONLY_EN: addresses 0xF0-0xFF run the address phase only.
module rtc_bus_protocol_ctrl #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 10,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_GAP   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_en_funcion_rtc,
    input  logic       in_funcion_w_r,
    input  logic [7:0] in_addr_ram_rtc,
    input  logic       in_flag_inicio,
    input  logic [7:0] in_dato_inicio,
    input  logic [7:0] in_dato_escritura,
    input  logic [7:0] in_ad_bus,
    output logic [7:0] out_ad_bus,
    output logic       out_ad_oe,
    output logic       out_cs_n,
    output logic       out_rd_n,
    output logic       out_wr_n,
    output logic       out_a_d,
    output logic [7:0] out_dato_leido,
    output logic [7:0] out_addr_leido,
    output logic       out_dato_valido,
    output logic       out_flag_done,
    output logic       out_busy
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_SETUP,
        S_ADDR_STROBE,
        S_ADDR_HOLD,
        S_GAP,
        S_DATA_SETUP,
        S_DATA_STROBE,
        S_DATA_HOLD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_w_r;
    logic [7:0]       r_addr;
    logic [7:0]       r_wdata;
    logic [7:0]       r_ad_bus;
    logic             r_ad_oe;
    logic             r_cs_n;
    logic             r_rd_n;
    logic             r_wr_n;
    logic             r_a_d;
    logic [7:0]       r_dato_leido;
    logic [7:0]       r_addr_leido;
    logic             r_dato_valido;
    logic             r_flag_done;
    logic             r_busy;

    logic w_last;
    logic w_cmd_only;

    assign w_last = (r_cnt == '0);

`ifdef RTC_CMD_ADDR_ONLY_EN
    assign w_cmd_only = (r_addr[7:4] == 4'hF);
`else
    assign w_cmd_only = 1'b0;
`endif

    // Every output is the registered value for the state being entered, so it changes with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_w_r         <= 1'b0;
            r_addr        <= 8'h00;
            r_wdata       <= 8'h00;
            r_ad_bus      <= 8'h00;
            r_ad_oe       <= 1'b0;
            r_cs_n        <= 1'b1;
            r_rd_n        <= 1'b1;
            r_wr_n        <= 1'b1;
            r_a_d         <= 1'b0;
            r_dato_leido  <= 8'h00;
            r_addr_leido  <= 8'h00;
            r_dato_valido <= 1'b0;
            r_flag_done   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_dato_valido <= 1'b0;
            r_flag_done   <= 1'b0;
            if (r_state != S_IDLE && !w_last) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (in_en_funcion_rtc) begin
                        r_w_r    <= in_funcion_w_r;
                        r_addr   <= in_addr_ram_rtc;
                        r_wdata  <= in_flag_inicio ? in_dato_inicio : in_dato_escritura;
                        r_state  <= S_ADDR_SETUP;
                        r_cnt    <= LD_SETUP;
                        r_cs_n   <= 1'b0;
                        r_a_d    <= 1'b0;
                        r_ad_oe  <= 1'b1;
                        r_ad_bus <= in_addr_ram_rtc;
                        r_busy   <= 1'b1;
                    end
                end
                S_ADDR_SETUP: begin
                    if (w_last) begin
                        r_state <= S_ADDR_STROBE;
                        r_cnt   <= LD_PULSE;
                        r_wr_n  <= 1'b0;
                    end
                end
                S_ADDR_STROBE: begin
                    if (w_last) begin
                        r_state <= S_ADDR_HOLD;
                        r_cnt   <= LD_HOLD;
                        r_wr_n  <= 1'b1;
                    end
                end
                S_ADDR_HOLD: begin
                    if (w_last) begin
                        r_cs_n  <= 1'b1;
                        r_ad_oe <= 1'b0;
                        if (w_cmd_only) begin
                            r_state     <= S_DONE;
                            r_a_d       <= 1'b0;
                            r_flag_done <= 1'b1;
                        end else begin
                            r_state <= S_GAP;
                            r_cnt   <= LD_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (w_last) begin
                        r_state <= S_DATA_SETUP;
                        r_cnt   <= LD_SETUP;
                        r_cs_n  <= 1'b0;
                        r_a_d   <= 1'b1;
                        r_ad_oe <= r_w_r;
                        if (r_w_r) begin
                            r_ad_bus <= r_wdata;
                        end
                    end
                end
                S_DATA_SETUP: begin
                    if (w_last) begin
                        r_state <= S_DATA_STROBE;
                        r_cnt   <= LD_PULSE;
                        if (r_w_r) begin
                            r_wr_n <= 1'b0;
                        end else begin
                            r_rd_n <= 1'b0;
                        end
                    end
                end
                S_DATA_STROBE: begin
                    // Read data is sampled on the edge that ends the final strobe cycle.
                    if (w_last) begin
                        r_state <= S_DATA_HOLD;
                        r_cnt   <= LD_HOLD;
                        r_wr_n  <= 1'b1;
                        r_rd_n  <= 1'b1;
                        if (!r_w_r) begin
                            r_dato_leido <= in_ad_bus;
                            r_addr_leido <= r_addr;
                        end
                    end
                end
                S_DATA_HOLD: begin
                    if (w_last) begin
                        r_state       <= S_DONE;
                        r_cs_n        <= 1'b1;
                        r_a_d         <= 1'b0;
                        r_ad_oe       <= 1'b0;
                        r_flag_done   <= 1'b1;
                        r_dato_valido <= !r_w_r;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cs_n  <= 1'b1;
                    r_rd_n  <= 1'b1;
                    r_wr_n  <= 1'b1;
                    r_ad_oe <= 1'b0;
                end
            endcase
        end
    end

    assign out_ad_bus      = r_ad_bus;
    assign out_ad_oe       = r_ad_oe;
    assign out_cs_n        = r_cs_n;
    assign out_rd_n        = r_rd_n;
    assign out_wr_n        = r_wr_n;
    assign out_a_d         = r_a_d;
    assign out_dato_leido  = r_dato_leido;
    assign out_addr_leido  = r_addr_leido;
    assign out_dato_valido = r_dato_valido;
    assign out_flag_done   = r_flag_done;
    assign out_busy        = r_busy;

endmodule

// File: tb/tb_rtc_bus_protocol_ctrl.sv
// Bench for rtc_bus_protocol_ctrl: table of accesses, back-to-back reads and a mid-access reset.
module tb_rtc_bus_protocol_ctrl;

    localparam int unsigned T_SETUP = 2;
    localparam int unsigned T_PULSE = 10;
    localparam int unsigned T_HOLD  = 2;
    localparam int unsigned T_GAP   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_en_funcion_rtc;
    logic       in_funcion_w_r;
    logic [7:0] in_addr_ram_rtc;
    logic       in_flag_inicio;
    logic [7:0] in_dato_inicio;
    logic [7:0] in_dato_escritura;
    logic [7:0] in_ad_bus;
    logic [7:0] out_ad_bus;
    logic       out_ad_oe;
    logic       out_cs_n;
    logic       out_rd_n;
    logic       out_wr_n;
    logic       out_a_d;
    logic [7:0] out_dato_leido;
    logic [7:0] out_addr_leido;
    logic       out_dato_valido;
    logic       out_flag_done;
    logic       out_busy;

    rtc_bus_protocol_ctrl #(
        .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD), .T_GAP(T_GAP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_en_funcion_rtc (in_en_funcion_rtc),
        .in_funcion_w_r    (in_funcion_w_r),
        .in_addr_ram_rtc   (in_addr_ram_rtc),
        .in_flag_inicio    (in_flag_inicio),
        .in_dato_inicio    (in_dato_inicio),
        .in_dato_escritura (in_dato_escritura),
        .in_ad_bus         (in_ad_bus),
        .out_ad_bus        (out_ad_bus),
        .out_ad_oe         (out_ad_oe),
        .out_cs_n          (out_cs_n),
        .out_rd_n          (out_rd_n),
        .out_wr_n          (out_wr_n),
        .out_a_d           (out_a_d),
        .out_dato_leido    (out_dato_leido),
        .out_addr_leido    (out_addr_leido),
        .out_dato_valido   (out_dato_valido),
        .out_flag_done     (out_flag_done),
        .out_busy          (out_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w_r;
        logic [7:0] addr;
        logic       inicio;
        logic [7:0] dini;
        logic [7:0] desc;
        logic [7:0] rdval;
        logic [7:0] exp_wdrive;
    } vec_t;

    typedef struct {
        logic [7:0] addr;
        logic       w_r;
        logic [7:0] wdata;
        int         lat;
        logic       valid;
        logic [7:0] leido;
        logic [7:0] addr_leido;
        logic       cmd;
    } exp_t;

    exp_t       sb[$];
    vec_t       tbl[7];
    logic [7:0] m_leido;
    logic [7:0] m_addr;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         pulse_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (out_flag_done === 1'b1) pulse_cnt <= pulse_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lim);
        total++;
        if (act < lim) begin
            bad++;
            $display("FAIL %s: actual=%0d required>=%0d", name, act, lim);
        end
    endtask

    function automatic logic is_cmd(input logic [7:0] a);
`ifdef RTC_CMD_ADDR_ONLY_EN
        return a[7:4] == 4'hF;
`else
        return (a == 8'h00) && (a != 8'h00);
`endif
    endfunction

    function automatic int lat_for(input logic [7:0] a);
        if (is_cmd(a)) return int'(T_SETUP + T_PULSE + T_HOLD + 1);
        return int'(2 * (T_SETUP + T_PULSE + T_HOLD) + T_GAP + 1);
    endfunction

    // Drives one access from a negedge and returns on the negedge where flag_done is seen.
    task automatic access(input vec_t v, input logic keep_en, output int done_cyc);
        exp_t e;
        int   n;
        logic seen;
        logic done_seen;
        int   addr_str, wdat_str, rd_str, dat_quiet, gap, viol;
        logic ad_seen;

        done_cyc          = cyc;
        in_funcion_w_r    = v.w_r;
        in_addr_ram_rtc   = v.addr;
        in_flag_inicio    = v.inicio;
        in_dato_inicio    = v.dini;
        in_dato_escritura = v.desc;
        in_en_funcion_rtc = 1'b1;
        e.addr  = v.addr;
        e.w_r   = v.w_r;
        e.wdata = v.exp_wdrive;
        e.cmd   = is_cmd(v.addr);
        e.lat   = lat_for(v.addr);
        if (!v.w_r && !e.cmd) begin
            m_leido = v.rdval;
            m_addr  = v.addr;
        end
        e.valid      = !v.w_r && !e.cmd;
        e.leido      = m_leido;
        e.addr_leido = m_addr;
        sb.push_back(e);

        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (!out_cs_n) seen = 1'b1;
            else if (k == 0) check("idle_between_accesses", 32'({out_flag_done, out_dato_valido, out_busy}), 32'(0));
        end
        if (!seen) begin
            check("accept_timeout", 32'(0), 32'(1));
            void'(sb.pop_front());
            in_en_funcion_rtc = 1'b0;
            return;
        end

        // Inputs after acceptance must not matter.
        if (!keep_en) in_en_funcion_rtc = 1'b0;
        in_addr_ram_rtc   = 8'($urandom);
        in_funcion_w_r    = 1'($urandom);
        in_flag_inicio    = 1'($urandom);
        in_dato_inicio    = 8'($urandom);
        in_dato_escritura = 8'($urandom);

        n = 1; done_seen = 1'b0;
        addr_str = 0; wdat_str = 0; rd_str = 0; dat_quiet = 0; gap = 0; viol = 0; ad_seen = 1'b0;
        while (!done_seen && n <= 80) begin
            if (!out_cs_n && !out_wr_n && !out_a_d && out_ad_oe && out_ad_bus == v.addr) addr_str++;
            if (!out_cs_n && !out_wr_n && out_a_d && out_ad_oe && out_ad_bus == e.wdata) wdat_str++;
            if (!out_cs_n && !out_rd_n && out_a_d && !out_ad_oe) rd_str++;
            if (!out_cs_n && out_a_d && out_rd_n && out_wr_n) dat_quiet++;
            if (out_cs_n && !out_flag_done) gap++;
            if (out_a_d) ad_seen = 1'b1;
            if ((out_ad_oe && !out_rd_n) || (!out_rd_n && !out_wr_n) ||
                (out_cs_n && (!out_rd_n || !out_wr_n || out_ad_oe)) || !out_busy ||
                (!out_cs_n && out_a_d && (out_ad_oe != e.w_r)) ||
                (out_dato_valido && !out_flag_done))
                viol++;
            if (out_flag_done) begin
                done_seen = 1'b1;
            end else begin
                in_ad_bus = !out_rd_n ? v.rdval : ~v.rdval;
                @(negedge clk);
                n++;
            end
        end
        if (!done_seen) begin
            check("done_timeout", 32'(0), 32'(1));
            void'(sb.pop_front());
            return;
        end
        done_cyc = cyc;
        e = sb.pop_front();
        check("latency", 32'(n), 32'(e.lat));
        check("addr_strobe_cycles", 32'(addr_str), 32'(T_PULSE));
        check("write_data_cycles", 32'(wdat_str), (e.w_r && !e.cmd) ? 32'(T_PULSE) : 32'(0));
        check("read_strobe_cycles", 32'(rd_str), (!e.w_r && !e.cmd) ? 32'(T_PULSE) : 32'(0));
        check("data_setup_hold_cycles", 32'(dat_quiet), e.cmd ? 32'(0) : 32'(T_SETUP + T_HOLD));
        check("gap_cycles", 32'(gap), e.cmd ? 32'(0) : 32'(T_GAP));
        check("a_d_seen", 32'(ad_seen), 32'(!e.cmd));
        check("protocol_violations", 32'(viol), 32'(0));
        check("dato_valido", 32'(out_dato_valido), 32'(e.valid));
        check("dato_leido", 32'(out_dato_leido), 32'(e.leido));
        check("addr_leido", 32'(out_addr_leido), 32'(e.addr_leido));
        if (!keep_en) begin
            @(negedge clk);
            check("after_done", 32'({out_flag_done, out_dato_valido, out_busy}), 32'(0));
        end
    endtask

    initial begin
        int   dc;
        int   prev;
        int   pc0;
        logic got;
        vec_t v;

        reset = 1'b0;
        in_en_funcion_rtc = 1'b0; in_funcion_w_r = 1'b0; in_addr_ram_rtc = 8'h00;
        in_flag_inicio = 1'b0; in_dato_inicio = 8'h00; in_dato_escritura = 8'h00; in_ad_bus = 8'h00;
        m_leido = 8'h00; m_addr = 8'h00;
        prev = 0;

        tbl[0] = '{1'b1, 8'h02, 1'b1, 8'h10, 8'h77, 8'h00, 8'h10};
        tbl[1] = '{1'b0, 8'h21, 1'b0, 8'h00, 8'h00, 8'h45, 8'h00};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 8'hD2, 8'h5A, 8'h00, 8'h5A};
        tbl[3] = '{1'b0, 8'h7F, 1'b1, 8'h11, 8'h22, 8'hA5, 8'h00};
        tbl[4] = '{1'b1, 8'hF0, 1'b1, 8'h3C, 8'hC3, 8'h00, 8'h3C};
        tbl[5] = '{1'b0, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h81, 8'h00};
        tbl[6] = '{1'b1, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};

        repeat (3) @(negedge clk);
        check("reset_state",
              {out_cs_n, out_rd_n, out_wr_n, out_a_d, out_ad_oe, out_ad_bus, out_dato_leido,
               out_addr_leido, out_dato_valido, out_flag_done, out_busy},
              {3'b111, 2'b00, 8'h00, 8'h00, 8'h00, 3'b000});
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) access(tbl[i], 1'b0, dc);

        // Request held high across eight reads; each finished access moves to the next address.
        pc0 = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            v = '{1'b0, (i < 7) ? 8'(8'h21 + i) : 8'hF1, 1'b0, 8'h00, 8'h00, 8'(8'h60 + 8'(i * 7)), 8'h00};
            access(v, 1'b1, dc);
            if (i > 0) check_ge("b2b_spacing", dc - prev, lat_for(v.addr) + 1);
            prev = dc;
        end
        in_en_funcion_rtc = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_pulse_count", 32'(pulse_cnt - pc0), 32'(8));
        check("b2b_idle", 32'({out_busy, out_cs_n}), 32'(2'b01));

        // Reset in the middle of a read data strobe.
        in_funcion_w_r = 1'b0; in_addr_ram_rtc = 8'h44; in_en_funcion_rtc = 1'b1;
        @(negedge clk);
        in_en_funcion_rtc = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (!out_rd_n) got = 1'b1;
        end
        check("reset_mid_reached_strobe", 32'(got), 32'(1));
        repeat (3) @(negedge clk);
        pc0 = pulse_cnt;
        #2 reset = 1'b0;
        #1;
        check("reset_mid_strobes", 32'({out_cs_n, out_rd_n, out_wr_n, out_ad_oe, out_busy}), 32'(5'b11100));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        m_leido = 8'h00; m_addr = 8'h00;
        repeat (40) @(negedge clk);
        check("reset_mid_no_done", 32'(pulse_cnt - pc0), 32'(0));
        check("reset_mid_cleared", 32'({out_dato_leido, out_addr_leido, out_busy}), 32'(0));
        access(tbl[1], 1'b0, dc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_bus_protocol_ctrl.md
Name: rtc_bus_protocol_ctrl

Overview:
- Physical-bus controller for the multiplexed address/data RTC. Sits directly downstream of the general RTC sequencing FSM.
- Accepts one register access at a time (address, write data, read/write select) and drives the address phase and then the data phase on the 8-bit AD bus with CS/RD/WR/A_D strobes.
- Returns read data plus a one-cycle done pulse; the FSM uses that pulse to advance its access counter.

Parameters:
- T_SETUP, 2, cycles AD/A_D/CS are stable before a strobe falls (min 1)
- T_PULSE, 10, cycles the RD_n/WR_n strobe stays low (min 1)
- T_HOLD, 2, cycles AD/CS are held after a strobe rises (min 1)
- T_GAP, 4, cycles CS is high between the address and data phases (min 1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_en_funcion_rtc  in  1  request; level, sampled only in IDLE
- in_funcion_w_r  in  1  1=write, 0=read
- in_addr_ram_rtc  in  8  RTC register address
- in_flag_inicio  in  1  1=write data comes from in_dato_inicio
- in_dato_inicio  in  8  init-sequence write data
- in_dato_escritura  in  8  configuration write data (used when in_flag_inicio=0)
- in_ad_bus  in  8  AD pads, input side
- out_ad_bus  out  8  AD pads, drive value
- out_ad_oe  out  1  1=drive AD pads (top level builds the tristate)
- out_cs_n  out  1  chip select, active low
- out_rd_n  out  1  read strobe, active low
- out_wr_n  out  1  write strobe, active low
- out_a_d  out  1  0=address phase, 1=data phase
- out_dato_leido  out  8  captured read data
- out_addr_leido  out  8  address of the access that produced out_dato_leido
- out_dato_valido  out  1  one-cycle pulse when out_dato_leido updates
- out_flag_done  out  1  one-cycle pulse at end of every access
- out_busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (reset=0, immediate, asynchronous):
  - state=IDLE
  - cs_n=rd_n=wr_n=1, a_d=0, ad_oe=0, ad_bus=0
  - dato_leido=0, addr_leido=0, dato_valido=0, flag_done=0, busy=0
- All outputs are registered. One shared 8-bit down-counter times every phase.
- IDLE:
  - Strobes are inactive.
  - If in_en_funcion_rtc=1, latch w_r, addr, and wdata (inicio or escritura, per in_flag_inicio), then go to ADDR_SETUP.
- ADDR_SETUP (T_SETUP cycles): cs_n=0, a_d=0, ad_oe=1, ad_bus=latched addr.
- ADDR_STROBE (T_PULSE cycles): as ADDR_SETUP, plus wr_n=0. The address is always written.
- ADDR_HOLD (T_HOLD cycles): wr_n=1; cs_n, ad_bus and ad_oe are unchanged.
- GAP (T_GAP cycles): cs_n=1, ad_oe=0.
- DATA_SETUP (T_SETUP cycles):
  - cs_n=0, a_d=1.
  - Write: ad_oe=1, ad_bus=wdata.
  - Read: ad_oe=0.
- DATA_STROBE (T_PULSE cycles):
  - Write: wr_n=0. Read: rd_n=0.
  - Read: in_ad_bus is captured into dato_leido on the clock edge that ends the last strobe cycle; addr_leido is updated on the same edge.
- DATA_HOLD (T_HOLD cycles): strobe=1; cs_n, a_d and the write drive are held.
- DONE (1 cycle):
  - cs_n=1, a_d=0, ad_oe=0, flag_done=1.
  - dato_valido=1 only for reads.
  - Next state is IDLE.
- Latency: acceptance edge to flag_done high = 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP+1 cycles. With the defaults this is 33.
- Back-to-back accesses: after DONE, IDLE lasts at least one cycle. The upstream counter has then incremented, so the next address is sampled fresh. Minimum spacing between flag_done pulses is latency+1 cycles.
- No abort: if in_en_funcion_rtc drops mid-access, the access still completes and flag_done still pulses.
- Input changes after acceptance are ignored until the next IDLE sample.
- Writes: dato_leido and addr_leido are unchanged.
- The controller never drives AD while rd_n=0 or during GAP.
- Reset mid-access: strobes go inactive immediately and no done pulse is issued.

Optional Feature:
- Macro: RTC_CMD_ADDR_ONLY_EN.
- Defined:
  - Addresses 0xF0–0xFF are command-only accesses.
  - After ADDR_HOLD the block skips GAP and all data states and goes straight to DONE.
  - dato_valido stays 0 for these accesses, regardless of w_r.
  - Latency = T_SETUP+T_PULSE+T_HOLD+1 (15 with the defaults).
- Undefined: every address performs both phases.

Test Plan:
- Write addr=0x02 with flag_inicio=1 and dato_inicio=0x10, defaults → address phase drives ad_bus=0x02 with wr_n low for 10 cycles; data phase drives 0x10 with a_d=1; flag_done high exactly 33 cycles after acceptance; dato_valido stays 0.
- Read addr=0x21 with in_ad_bus=0x45 during DATA_STROBE → ad_oe=0 throughout the data phase; dato_leido=0x45, addr_leido=0x21; dato_valido and flag_done each pulse for one cycle.
- in_en_funcion_rtc held high across 8 sequential reads (0x21–0x27, 0xF1) → exactly 8 flag_done pulses, each separated by ≥34 cycles; no cs_n glitch during GAP→IDLE.
- in_flag_inicio=0, in_dato_escritura=0x5A, in_dato_inicio=0xD2, write → data phase drives 0x5A.
- reset driven to 0 mid DATA_STROBE → cs_n, rd_n and wr_n go to 1 without waiting for a clock edge; no flag_done; next access after reset release is normal.
- RTC_CMD_ADDR_ONLY_EN defined, write addr=0xF0 → a_d never goes to 1; flag_done 15 cycles after acceptance. Undefined → 33 cycles.
